// File: rtl/dmem_lsu.sv
// Byte-lane data memory with a valid/ready load/store port and sign/zero-extended loads.
// Latency: one cycle (an accept at edge N gives rsp_valid in cycle N+1); one request per cycle.
// Backpressure: a one-entry response register; req_ready drops while the response is held.
module dmem_lsu #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_dext,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    logic [3:0][7:0] r_mem [DEPTH];

    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_fault;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic          w_in_range;
    logic          w_misalign;
    logic          w_bad_dext;
    logic          w_bad_store;
    logic          w_fault;
    logic          w_accept;
    logic          w_mem_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_rd_sh;
    logic [31:0]   w_load;
    logic [31:0]   w_rsp_dat;

    assign w_idx = req_addr[AW+1:2];
    assign w_off = req_addr[1:0];

    // Below 4*DEPTH covers both the upper address bits and a non-power-of-two DEPTH.
    assign w_in_range  = req_addr < 32'(DEPTH * 4);
    assign w_misalign  = ((req_dext[1:0] == 2'b01) && (w_off == 2'b11)) ||
                         ((req_dext[1:0] == 2'b10) && (w_off != 2'b00));
    assign w_bad_dext  = (req_dext == 3'b011) || (req_dext[2:1] == 2'b11);
    assign w_bad_store = req_we && req_dext[2];
    assign w_fault     = !w_in_range || w_misalign || w_bad_dext || w_bad_store;

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready && !reset;
    assign w_mem_we  = w_accept && req_we && !w_fault;

    always_comb begin
        w_be = 4'b0000;
        case (req_dext[1:0])
            2'b00:   w_be = 4'b0001 << w_off;
            2'b01:   w_be = 4'b0011 << w_off;
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_wdata_sh = req_wdata << {w_off, 3'b000};

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][i] <= w_wdata_sh[8*i +: 8];
            end
        end
    end

    assign w_rd_word = r_mem[w_idx];
    assign w_rd_sh   = w_rd_word >> {w_off, 3'b000};

    always_comb begin
        w_load = 32'd0;
        case (req_dext)
            3'b000:  w_load = {{24{w_rd_sh[7]}}, w_rd_sh[7:0]};
            3'b100:  w_load = {24'd0, w_rd_sh[7:0]};
            3'b001:  w_load = {{16{w_rd_sh[15]}}, w_rd_sh[15:0]};
            3'b101:  w_load = {16'd0, w_rd_sh[15:0]};
            3'b010:  w_load = w_rd_sh;
            default: w_load = 32'd0;
        endcase
    end

    assign w_rsp_dat = (w_fault || req_we) ? 32'd0 : w_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_dat;
            r_rsp_fault <= w_fault;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;

endmodule
